// File: rtl/bev_vend_pkg.sv
// Shared types and default configuration for the beverage vending machine.
package bev_vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_REFUND   = 2'd3
  } vend_state_e;

  // Product i price lives in bits [4*i +: 4]: product 0 costs 1, product 3 costs 4.
  localparam logic [15:0] DEF_PRICES   = {4'd4, 4'd3, 4'd2, 4'd1};
  localparam int          DEF_DISP_CYC = 4;

endpackage

// File: rtl/bev_pulse_timer.sv
// Loadable down-counter; done_o is high whenever the count has reached zero.
module bev_pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/bev_vend_machine.sv
// Coin-operated vending controller: credit accumulation, product dispense,
// refund on cancel or inactivity. All outputs come straight from registers.
module bev_vend_machine
  import bev_vend_pkg::*;
#(
  parameter int NUM_PROD    = 4,
  parameter int CREDIT_W    = 4,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = DEF_PRICES,
  parameter int DISP_CYC    = DEF_DISP_CYC,
  parameter int TIMEOUT_CYC = 64,
  localparam int SEL_W      = $clog2(NUM_PROD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin,
  input  logic [SEL_W-1:0]    user_in,
  input  logic                sel_valid,
  input  logic                cancel,
  output logic [NUM_PROD-1:0] dispense,
  output logic                coin_ret,
  output logic                coin_reject,
  output logic                sel_err,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] MAX_CREDIT = '1;
  localparam int DW = $clog2(DISP_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  // Timers count down to zero, so a load of N-1 gives an N-cycle window.
  localparam logic [DW-1:0] DISP_LOAD = DW'(DISP_CYC - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYC - 1);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [NUM_PROD-1:0] disp_q, disp_d;
  logic                ret_q, ret_d;
  logic                rej_q, rej_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                disp_load, disp_done;
  logic                to_load, to_done;
  logic                coin_acc, sel_ok;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] coin_add;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] s);
    price_of = '0;
    for (int i = 0; i < NUM_PROD; i++)
      if (int'(s) == i) price_of = PRICES[i*CREDIT_W +: CREDIT_W];
  endfunction

  assign price    = price_of(user_in);
  assign coin_acc = coin && (credit_q != MAX_CREDIT);
  assign coin_add = CREDIT_W'(coin_acc);
  // Affordability is judged on the registered credit, before any same-cycle coin.
  assign sel_ok   = (int'(user_in) < NUM_PROD) && (credit_q >= price);

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    disp_d    = '0;
    rej_d     = 1'b0;
    err_d     = 1'b0;
    disp_load = 1'b0;
    to_load   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        err_d = sel_valid;
        if (coin) begin
          credit_d = CREDIT_W'(1);
          state_d  = S_CREDIT;
          to_load  = 1'b1;
        end
      end
      S_CREDIT: begin
        to_load = coin || sel_valid || cancel;
        rej_d   = coin && !coin_acc;
        if (cancel) begin
          credit_d = credit_q + coin_add;
          state_d  = S_REFUND;
        end else if (sel_valid && sel_ok) begin
          credit_d  = credit_q - price + coin_add;
          disp_d    = NUM_PROD'(1) << user_in;
          disp_load = 1'b1;
          state_d   = S_DISPENSE;
        end else begin
          err_d    = sel_valid;
          credit_d = credit_q + coin_add;
          if (!coin && !sel_valid && to_done) state_d = S_REFUND;
        end
      end
      S_DISPENSE: begin
        rej_d = coin;
        err_d = sel_valid;
        if (disp_done) state_d = (credit_q != '0) ? S_REFUND : S_IDLE;
        else           disp_d  = disp_q;
      end
      S_REFUND: begin
        rej_d = coin;
        err_d = sel_valid;
        if (credit_q != '0) credit_d = credit_q - 1'b1;
        if (credit_q <= CREDIT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A return pulse is shown alongside the coin it returns, so credit is never 0 then.
    ret_d  = (state_d == S_REFUND) && (credit_d != '0);
    busy_d = (state_d == S_DISPENSE) || (state_d == S_REFUND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      disp_q   <= '0;
      ret_q    <= 1'b0;
      rej_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      disp_q   <= disp_d;
      ret_q    <= ret_d;
      rej_q    <= rej_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  bev_pulse_timer #(.W(DW)) u_disp_tmr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (disp_load),
    .load_val_i (DISP_LOAD),
    .en_i       (state_q == S_DISPENSE),
    .done_o     (disp_done)
  );

  bev_pulse_timer #(.W(TW)) u_to_tmr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (to_load),
    .load_val_i (TO_LOAD),
    .en_i       (state_q == S_CREDIT),
    .done_o     (to_done)
  );

  assign dispense    = disp_q;
  assign coin_ret    = ret_q;
  assign coin_reject = rej_q;
  assign sel_err     = err_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bev_vend_machine.sv
// Scenario bench for bev_vend_machine: expected pulse counts are queued as
// stimulus is driven and compared against monitored output activity.
module tb_bev_vend_machine;

  localparam int K_DISP0 = 0;
  localparam int K_RET   = 4;
  localparam int K_REJ   = 5;
  localparam int K_ERR   = 6;
  localparam int K_VIOL  = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin = 1'b0;
  logic [1:0] user_in = 2'd0;
  logic       sel_valid = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] dispense;
  logic       coin_ret, coin_reject, sel_err, busy;
  logic [3:0] credit;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt  [0:7];
  int base [0:7];

  typedef struct {
    string tag;
    int    kind;
    int    val;
  } exp_t;
  exp_t sb_q[$];

  bev_vend_machine dut (
    .clk         (clk),
    .rst         (rst),
    .coin        (coin),
    .user_in     (user_in),
    .sel_valid   (sel_valid),
    .cancel      (cancel),
    .dispense    (dispense),
    .coin_ret    (coin_ret),
    .coin_reject (coin_reject),
    .sel_err     (sel_err),
    .credit      (credit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial for (int k = 0; k < 8; k++) cnt[k] = 0;

  // Output activity counters, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (dispense[k]) cnt[k] = cnt[k] + 1;
    if (coin_ret)    cnt[K_RET] = cnt[K_RET] + 1;
    if (coin_reject) cnt[K_REJ] = cnt[K_REJ] + 1;
    if (sel_err)     cnt[K_ERR] = cnt[K_ERR] + 1;
    if ((coin_ret && credit == 4'd0) || ($countones(dispense) > 1))
      cnt[K_VIOL] = cnt[K_VIOL] + 1;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic sv, input logic [1:0] s, input logic cn);
    coin = c; sel_valid = sv; user_in = s; cancel = cn;
    tick();
    coin = 1'b0; sel_valid = 1'b0; user_in = 2'd0; cancel = 1'b0;
  endtask

  task automatic coins(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic snap();
    for (int k = 0; k < 8; k++) base[k] = cnt[k];
  endtask

  task automatic expect_ev(input string tag, input int kind, input int val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, cnt[e.kind] - base[e.kind], e.val);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(busy == 1'b0 && credit == 4'd0) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, int'(busy == 1'b0 && credit == 4'd0), 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_credit", int'(credit), 0);
    chk("rst_disp", int'(dispense), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ret", int'(coin_ret), 0);
    rst = 1'b0;
    tick();

    // IDLE: selection is an error, cancel ignored
    drive(1'b0, 1'b1, 2'd1, 1'b0);
    chk("idle_selerr", int'(sel_err), 1);
    drive(1'b0, 1'b0, 2'd0, 1'b1);
    chk("idle_cancel_busy", int'(busy), 0);
    chk("idle_cancel_credit", int'(credit), 0);

    // 3 coins, select 2 (price 3)
    snap();
    coins(3);
    chk("s1_credit", int'(credit), 3);
    drive(1'b0, 1'b1, 2'd2, 1'b0);
    chk("s1_disp_now", int'(dispense), 4);
    chk("s1_credit_after", int'(credit), 0);
    expect_ev("s1_disp2", K_DISP0 + 2, 4);
    expect_ev("s1_disp0", K_DISP0 + 0, 0);
    expect_ev("s1_ret", K_RET, 0);
    wait_idle("s1_idle", 20);
    sb_drain();

    // 4 coins, select 0 (price 1), with coin/select/cancel during dispense
    snap();
    coins(4);
    drive(1'b0, 1'b1, 2'd0, 1'b0);
    chk("s2_disp_now", int'(dispense), 1);
    chk("s2_credit", int'(credit), 3);
    drive(1'b1, 1'b1, 2'd2, 1'b1);
    chk("s2_rej", int'(coin_reject), 1);
    chk("s2_err", int'(sel_err), 1);
    chk("s2_disp_hold", int'(dispense), 1);
    expect_ev("s2_disp0", K_DISP0 + 0, 4);
    expect_ev("s2_ret", K_RET, 3);
    expect_ev("s2_rej_cnt", K_REJ, 1);
    wait_idle("s2_idle", 30);
    sb_drain();

    // 1 coin, select 3 (price 4) is refused, then cancel
    snap();
    coins(1);
    drive(1'b0, 1'b1, 2'd3, 1'b0);
    chk("s3_selerr", int'(sel_err), 1);
    chk("s3_credit", int'(credit), 1);
    chk("s3_disp", int'(dispense), 0);
    drive(1'b0, 1'b0, 2'd0, 1'b1);
    chk("s3_busy", int'(busy), 1);
    expect_ev("s3_ret", K_RET, 1);
    expect_ev("s3_disp3", K_DISP0 + 3, 0);
    expect_ev("s3_err_cnt", K_ERR, 1);
    wait_idle("s3_idle", 10);
    sb_drain();

    // Saturate credit, reject a coin, then inactivity refund
    snap();
    coins(15);
    chk("s4_credit15", int'(credit), 15);
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    chk("s4_reject", int'(coin_reject), 1);
    chk("s4_credit_hold", int'(credit), 15);
    repeat (63) tick();
    chk("s4_no_early_to", int'(busy), 0);
    tick();
    chk("s4_to_fire", int'(busy), 1);
    chk("s4_to_ret", int'(coin_ret), 1);
    expect_ev("s4_ret", K_RET, 15);
    expect_ev("s4_rej_cnt", K_REJ, 1);
    wait_idle("s4_idle", 40);
    sb_drain();

    // Cancel beats select; same-cycle coin joins the refund
    snap();
    coins(2);
    drive(1'b1, 1'b1, 2'd1, 1'b1);
    chk("s5_credit", int'(credit), 3);
    chk("s5_ret", int'(coin_ret), 1);
    chk("s5_noerr", int'(sel_err), 0);
    expect_ev("s5_ret_cnt", K_RET, 3);
    expect_ev("s5_disp1", K_DISP0 + 1, 0);
    expect_ev("s5_err_cnt", K_ERR, 0);
    wait_idle("s5_idle", 10);
    sb_drain();

    // Reset in the second dispense cycle forfeits everything
    snap();
    coins(4);
    drive(1'b0, 1'b1, 2'd0, 1'b0);
    tick();
    chk("s6_disp_c2", int'(dispense), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_disp", int'(dispense), 0);
    chk("s6_credit", int'(credit), 0);
    chk("s6_busy", int'(busy), 0);
    chk("s6_ret", int'(coin_ret), 0);
    repeat (8) tick();
    expect_ev("s6_disp0", K_DISP0 + 0, 2);
    expect_ev("s6_ret_cnt", K_RET, 0);
    sb_drain();
    chk("s6_still_idle", int'(busy) + int'(credit), 0);

    chk("invariants", cnt[K_VIOL], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
